// File: rtl/frame_gen_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared types, constants and helpers for the frame_gen serialiser.
//   state_t        : FSM states (IDLE, SHIFT)
//   CRC8_POLY      : CRC-8 polynomial x^8+x^2+x+1
//   DEFAULT_HEADER : header byte giving 1010 on both I and Q after the IQ split
//   frame_bits()   : total serial bits per frame (header + payload + check)
//   crc8_step()    : one bit-serial CRC-8 update, MSB-first, no reflection
// -----------------------------------------------------------------------------
package frame_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [7:0] CRC8_POLY      = 8'h07;
    localparam logic [7:0] DEFAULT_HEADER = 8'hCC;

    function automatic int unsigned frame_bits(input int unsigned payload_bytes);
        return 32'd8 * (payload_bytes + 32'd2);
    endfunction

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/frame_gen_if.sv
// -----------------------------------------------------------------------------
// frame_gen_if
// Groups the frame request and serial output signals of frame_gen.
//   payload_i : parallel payload, most significant byte sent first
//   start_i   : frame request (only acted on while the generator is idle)
//   ser_o     : serial frame bit
//   bit_stb_o : pulse on the first clock of each bit period
//   busy_o    : frame in progress
//   done_o    : one-cycle pulse when a frame completes
// Modports: master drives the request side, slave is the generator.
// -----------------------------------------------------------------------------
interface frame_gen_if #(
    parameter int unsigned PAYLOAD_BYTES = 32'd3
);
    logic [8*PAYLOAD_BYTES-1:0] payload_i;
    logic                       start_i;
    logic                       ser_o;
    logic                       bit_stb_o;
    logic                       busy_o;
    logic                       done_o;

    modport master (
        output payload_i,
        output start_i,
        input  ser_o,
        input  bit_stb_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  payload_i,
        input  start_i,
        output ser_o,
        output bit_stb_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/frame_gen_crc8.sv
// -----------------------------------------------------------------------------
// frame_crc8
// Bit-serial CRC-8 (poly 0x07, init 0x00, no reflection, no xor-out).
//   clk, rst : clock and asynchronous active-high reset
//   clr      : restart the CRC from 0x00
//   en       : fold din into the CRC on this edge
//   din      : serial data bit, MSB-first
//   crc      : current CRC register
// clr and en may be asserted together: the first bit of a new frame is then
// folded into a freshly cleared register on the same edge.
// -----------------------------------------------------------------------------
module frame_crc8
    import frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);
    logic [7:0] crc_r;
    logic [7:0] base_s;

    // Starting value for this edge: cleared register on a new frame
    always_comb begin
        base_s = crc_r;
        if (clr) begin
            base_s = 8'h00;
        end else begin
            base_s = crc_r;
        end
    end

    // CRC register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_r <= 8'h00;
        end else if (en) begin
            crc_r <= crc8_step(base_s, din);
        end else begin
            crc_r <= base_s;
        end
    end

    assign crc = crc_r;
endmodule

// File: rtl/frame_gen.sv
// -----------------------------------------------------------------------------
// frame_gen
// Frame builder and serialiser for the QPSK modulator bit input. On a start
// request while idle it latches the payload, builds {HEADER, payload, check}
// and shifts it out MSB-first, one bit every BIT_DIV clocks.
//   sys_clk   : system clock
//   sys_rst   : asynchronous reset, active-high
//   bus       : frame_gen_if.slave (payload_i, start_i, ser_o, bit_stb_o,
//               busy_o, done_o)
// Parameters: PAYLOAD_BYTES (1..16), HEADER, BIT_DIV (>=1).
// Build option FRAME_GEN_CRC8_EN: when defined the check byte is a CRC-8
// computed bit-serially over header and payload as they are sent; otherwise
// it is the 8-bit additive checksum of header and payload bytes.
// All outputs are registered; they are computed from the next-state values.
// -----------------------------------------------------------------------------
module frame_gen
    import frame_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES = 32'd3,
    parameter logic [7:0]  HEADER        = DEFAULT_HEADER,
    parameter int unsigned BIT_DIV       = 32'd4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    frame_gen_if.slave bus
);
    localparam int unsigned FRAME_BITS = frame_bits(PAYLOAD_BYTES);
`ifdef FRAME_GEN_CRC8_EN
    localparam int unsigned DATA_BITS  = FRAME_BITS - 32'd8;
    localparam int unsigned SHREG_BITS = DATA_BITS;
`else
    localparam int unsigned SHREG_BITS = FRAME_BITS;
`endif
    localparam int unsigned DIV_W    = (BIT_DIV > 32'd1) ? $clog2(BIT_DIV) : 32'd1;
    localparam int unsigned CNT_W    = $clog2(FRAME_BITS + 32'd1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 32'd1);

    state_t                state_r, state_s;
    logic [DIV_W-1:0]      div_r, div_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [SHREG_BITS-1:0] shreg_r, shreg_s, load_s;
    logic                  ser_r, stb_r, busy_r, done_r;
    logic                  ser_s, stb_s, busy_s, done_s;

`ifdef FRAME_GEN_CRC8_EN
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_BITS);

    logic [7:0] crc_s;
    logic       crc_en_s;
    logic       crc_clr_s;
    logic [2:0] ofs_s;

    // Only header and payload are loaded; the CRC supplies the last byte
    assign load_s = {HEADER, bus.payload_i};

    // The CRC advances on the edge that opens each data bit, so the register
    // is final by the time the first check bit is due, even with BIT_DIV=1.
    assign crc_clr_s = (state_r == IDLE) && bus.start_i;
    assign crc_en_s  = stb_s && (cnt_s < CNT_DATA);
    assign ofs_s     = 3'(cnt_s - CNT_DATA);

    frame_crc8 u_crc (
        .clk (sys_clk),
        .rst (sys_rst),
        .clr (crc_clr_s),
        .en  (crc_en_s),
        .din (shreg_s[SHREG_BITS-1]),
        .crc (crc_s)
    );
`else
    logic [7:0] chk_s;

    // Additive checksum of header and payload bytes, modulo 256
    always_comb begin
        chk_s = HEADER;
        for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
            chk_s = chk_s + bus.payload_i[8*i +: 8];
        end
    end

    assign load_s = {HEADER, bus.payload_i, chk_s};
`endif

    // Next-state logic: divider, bit counter and shift register
    always_comb begin
        state_s = state_r;
        div_s   = div_r;
        cnt_s   = cnt_r;
        shreg_s = shreg_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    state_s = SHIFT;
                    div_s   = '0;
                    cnt_s   = '0;
                    shreg_s = load_s;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (div_r == DIV_LAST) begin
                    div_s   = '0;
                    shreg_s = {shreg_r[SHREG_BITS-2:0], 1'b0};
                    if (cnt_r == CNT_LAST) begin
                        state_s = IDLE;
                        cnt_s   = '0;
                        done_s  = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 1'b1;
                    end
                end else begin
                    div_s = div_r + 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                div_s   = '0;
                cnt_s   = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        busy_s = (state_s == SHIFT);
        stb_s  = busy_s && (div_s == '0);
        ser_s  = 1'b0;
        if (!busy_s) begin
            ser_s = 1'b0;
`ifdef FRAME_GEN_CRC8_EN
        end else if (cnt_s >= CNT_DATA) begin
            ser_s = crc_s[3'd7 - ofs_s];
`endif
        end else begin
            ser_s = shreg_s[SHREG_BITS-1];
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_r   <= '0;
            cnt_r   <= '0;
            shreg_r <= '0;
            ser_r   <= 1'b0;
            stb_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            div_r   <= div_s;
            cnt_r   <= cnt_s;
            shreg_r <= shreg_s;
            ser_r   <= ser_s;
            stb_r   <= stb_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.ser_o     = ser_r;
    assign bus.bit_stb_o = stb_r;
    assign bus.busy_o    = busy_r;
    assign bus.done_o    = done_r;
endmodule

// File: tb/tb_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_frame_gen
// Two generators: BIT_DIV=4 (directed and random frames, mid-frame restarts,
// back-to-back frames, reset in bit 20) and BIT_DIV=1 (start held high with a
// payload that changes every clock). Accepted requests push a frame record
// into a per-DUT queue; negedge monitors compare every output every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_gen;
    localparam int unsigned PB  = 3;
    localparam int unsigned F   = 8 * (PB + 2);
    localparam int          D0  = 4;
    localparam int          D1  = 1;
    localparam logic [7:0]  HDR = 8'hCC;

    typedef struct {
        longint         start;
        logic [F-1:0]   bits;
    } rec_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    frame_gen_if #(.PAYLOAD_BYTES(PB)) bus0 ();
    frame_gen_if #(.PAYLOAD_BYTES(PB)) bus1 ();

    frame_gen #(.PAYLOAD_BYTES(PB), .HEADER(HDR), .BIT_DIV(D0)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus0));
    frame_gen #(.PAYLOAD_BYTES(PB), .HEADER(HDR), .BIT_DIV(D1)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus1));

    rec_t   q0[$];
    rec_t   q1[$];
    longint cyc   = 0;
    longint free0 = 0;
    longint free1 = 0;
    int     vectors     = 0;
    int     miscompares = 0;
    bit     stop1 = 1'b0;
    bit     done1 = 1'b0;

    // Check byte from first principles: byte sum, or CRC as polynomial division
    function automatic logic [7:0] ref_check(input logic [8*PB-1:0] pl);
`ifdef FRAME_GEN_CRC8_EN
        logic [8*PB+15:0] rem;
        rem = {HDR, pl, 8'h00};
        for (int i = 8*PB + 15; i >= 8; i--) begin
            if (rem[i]) rem[i -: 9] = rem[i -: 9] ^ 9'h107;
        end
        return rem[7:0];
`else
        int s;
        s = int'(HDR);
        for (int i = 0; i < int'(PB); i++) s = s + int'(pl[8*i +: 8]);
        return 8'(s % 256);
`endif
    endfunction

    // Expected {ser, stb, busy, done} rel cycles after the accepting edge
    function automatic logic [3:0] expect_out(input logic [F-1:0] bits, input longint rel, input int d);
        longint span;
        int     idx;
        span = longint'(F) * longint'(d);
        if (rel < span) begin
            idx = int'(F) - 1 - int'(rel / longint'(d));
            return {bits[idx], (rel % longint'(d)) == 0, 1'b1, 1'b0};
        end
        return 4'b0001;
    endfunction

    task automatic check_out(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d ser/stb/busy/done got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse0(input logic [8*PB-1:0] pl);
        bus0.payload_i = pl;
        bus0.start_i   = 1'b1;
        tick(1);
        bus0.start_i   = 1'b0;
    endtask

    // Request sampler: a start is taken only once the previous frame is over
    always @(posedge sys_clk) begin : sampler
        longint c;
        rec_t   r;
        c = cyc + 1;
        cyc <= c;
        if (sys_rst) begin
            free0 <= 0;
            free1 <= 0;
        end else begin
            if (bus0.start_i && c >= free0) begin
                r.start = c;
                r.bits  = {HDR, bus0.payload_i, ref_check(bus0.payload_i)};
                q0.push_back(r);
                free0 <= c + longint'(F) * D0 + 1;
            end
            if (bus1.start_i && c >= free1) begin
                r.start = c;
                r.bits  = {HDR, bus1.payload_i, ref_check(bus1.payload_i)};
                q1.push_back(r);
                free1 <= c + longint'(F) * D1 + 1;
            end
        end
    end

    always @(negedge sys_clk) begin : mon0
        logic [3:0] e;
        longint     rel;
        e = 4'b0000;
        if (sys_rst) begin
            q0.delete();
        end else if (q0.size() > 0) begin
            rel = cyc - q0[0].start;
            e = expect_out(q0[0].bits, rel, D0);
            if (rel >= longint'(F) * D0) void'(q0.pop_front());
        end
        check_out("div4", {bus0.ser_o, bus0.bit_stb_o, bus0.busy_o, bus0.done_o}, e);
    end

    always @(negedge sys_clk) begin : mon1
        logic [3:0] e;
        longint     rel;
        e = 4'b0000;
        if (sys_rst) begin
            q1.delete();
        end else if (q1.size() > 0) begin
            rel = cyc - q1[0].start;
            e = expect_out(q1[0].bits, rel, D1);
            if (rel >= longint'(F) * D1) void'(q1.pop_front());
        end
        check_out("div1", {bus1.ser_o, bus1.bit_stb_o, bus1.busy_o, bus1.done_o}, e);
    end

    // BIT_DIV=1 generator: start held high, payload changing every clock
    initial begin : stim1
        bus1.start_i   = 1'b0;
        bus1.payload_i = '0;
        tick(6);
        bus1.start_i = 1'b1;
        for (int n = 0; n < 60000 && !stop1; n++) begin
            bus1.payload_i = (8*PB)'($urandom);
            tick(1);
        end
        bus1.start_i = 1'b0;
        tick(int'(F) * D1 + 4);
        done1 = 1'b1;
    end

    initial begin : stim0
        bus0.start_i   = 1'b0;
        bus0.payload_i = '0;
        sys_rst = 1'b1;
        tick(3);
        sys_rst = 1'b0;
        tick(2);

        // Reference frame CC 12 34 56 68, then an all-zero payload
        pulse0(24'h123456);
        bus0.payload_i = 24'hFFFFFF;
        tick(int'(F) * D0 + 3);
        pulse0(24'h000000);
        tick(int'(F) * D0 + 3);

        // Random frames with a second request and payload change mid-frame
        for (int k = 0; k < 6; k++) begin
            pulse0((8*PB)'($urandom));
            tick(int'($urandom_range(10, 100)));
            pulse0((8*PB)'($urandom));
            tick(int'(F) * D0 + int'($urandom_range(0, 4)));
        end

        // Start held high: frames follow each other with a single idle cycle
        bus0.start_i = 1'b1;
        for (int n = 0; n < 3 * (int'(F) * D0 + 1); n++) begin
            bus0.payload_i = (8*PB)'($urandom);
            tick(1);
        end
        bus0.start_i = 1'b0;
        tick(int'(F) * D0 + 3);

        // Reset during bit 20: outputs clear at once, no done pulse
        pulse0((8*PB)'($urandom));
        tick(20 * D0 + 1);
        #2;
        sys_rst = 1'b1;
        #1;
        check_out("rst_div4", {bus0.ser_o, bus0.bit_stb_o, bus0.busy_o, bus0.done_o}, 4'b0000);
        check_out("rst_div1", {bus1.ser_o, bus1.bit_stb_o, bus1.busy_o, bus1.done_o}, 4'b0000);
        tick(2);
        sys_rst = 1'b0;
        tick(1);
        pulse0((8*PB)'($urandom));
        tick(int'(F) * D0 + 4);

        stop1 = 1'b1;
        for (int n = 0; n < 2000 && !done1; n++) tick(1);
        if (!done1) begin
            miscompares++;
            $display("FAIL div1_finish got not finished expected finished");
        end
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
